// File: rtl/arb4_rr_ctrl.sv
// arb4_rr_ctrl: four-requester round-robin arbiter driving a 2-to-4 decoder
// stage. Grants are one-hot active-low, SEL/G_L feed the decoder, and every
// output is registered. A GAP cycle always separates two grants.
// Optional feature macro: ARB4_TENURE_EN limits each tenure to HOLD_MAX cycles.
//
// Handshake: REQ_L[i] low is a request; the owner keeps it low to keep the
// grant and raises it to release. GNT_L[i] low means requester i owns the
// resource for that cycle. EN_L high aborts any grant and blocks arbitration.
module arb4_rr_ctrl #(
    parameter int HOLD_MAX = 15,
    parameter int CW       = 4
) (
    input  logic       CLK,
    input  logic       RESET_L,
    input  logic       EN_L,
    input  logic [3:0] REQ_L,
    output logic [3:0] GNT_L,
    output logic [1:0] SEL,
    output logic       G_L,
    output logic       BUSY,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Tenure counter must be able to hold HOLD_MAX - 1.
    if (HOLD_MAX < 1 || HOLD_MAX >= (1 << CW)) begin : g_param_check
        $error("arb4_rr_ctrl: HOLD_MAX must be in 1 .. 2**CW-1");
    end

    state_t     state, state_n;
    logic [3:0] gnt_n;
    logic [1:0] sel_n;
    logic       g_n;
    logic       busy_n;
    logic [1:0] ptr, ptr_n;
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic       tenure_hit;
    logic       issue;

`ifdef ARB4_TENURE_EN
    logic [CW-1:0] cnt;

    assign tenure_hit = (cnt == CW'(HOLD_MAX - 1));

    // Tenure counter: cleared on grant issue, counts each GRANT cycle.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            cnt <= '0;
        end else if (issue) begin
            cnt <= '0;
        end else if (state == S_GRANT) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign tenure_hit = 1'b0;
`endif

    assign dbg_state = state;

    // Round-robin search: first low request starting at ptr, wrapping mod 4.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + k[1:0];
            if (!found && !REQ_L[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_n = state;
        gnt_n   = GNT_L;
        sel_n   = SEL;
        g_n     = G_L;
        busy_n  = BUSY;
        ptr_n   = ptr;
        issue   = 1'b0;
        case (state)
            S_GRANT: begin
                // Release, abort or tenure expiry all end the grant; other
                // requesters are never handed the resource directly.
                if (REQ_L[SEL] || EN_L || tenure_hit) begin
                    state_n = S_GAP;
                    gnt_n   = 4'b1111;
                    g_n     = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                if (!EN_L && found) begin
                    state_n = S_GRANT;
                    gnt_n   = ~(4'b0001 << win);
                    sel_n   = win;
                    g_n     = 1'b0;
                    busy_n  = 1'b1;
                    ptr_n   = win + 2'd1;
                    issue   = 1'b1;
                end else begin
                    state_n = S_IDLE;
                    gnt_n   = 4'b1111;
                    g_n     = 1'b1;
                    busy_n  = 1'b0;
                end
            end
        endcase
    end

    // State, pointer and registered outputs.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state <= S_IDLE;
            GNT_L <= 4'b1111;
            SEL   <= 2'b00;
            G_L   <= 1'b1;
            BUSY  <= 1'b0;
            ptr   <= 2'b00;
        end else begin
            state <= state_n;
            GNT_L <= gnt_n;
            SEL   <= sel_n;
            G_L   <= g_n;
            BUSY  <= busy_n;
            ptr   <= ptr_n;
        end
    end

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Bench for arb4_rr_ctrl: directed sequences, a cycle model of the
// round-robin rules checked every cycle, and literal checks at key points.
`timescale 1ns/1ps
module tb_arb4_rr_ctrl;

    localparam int HOLD = 4;
`ifdef ARB4_TENURE_EN
    localparam bit TENURE = 1'b1;
`else
    localparam bit TENURE = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET_L;
    logic       EN_L;
    logic [3:0] REQ_L;
    logic [3:0] GNT_L;
    logic [1:0] SEL;
    logic       G_L;
    logic       BUSY;
    logic [1:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_on  = 1'b0;

    // Model: owner (-1 = none), last winner, last select, tenure cycles.
    int         m_owner = -1;
    int         m_last  = 3;
    logic [1:0] m_sel   = 2'd0;
    int         m_ten   = 0;

    // clock / reset
    always #5 CLK = ~CLK;

    arb4_rr_ctrl #(.HOLD_MAX(HOLD), .CW(4)) dut (
        .CLK      (CLK),
        .RESET_L  (RESET_L),
        .EN_L     (EN_L),
        .REQ_L    (REQ_L),
        .GNT_L    (GNT_L),
        .SEL      (SEL),
        .G_L      (G_L),
        .BUSY     (BUSY),
        .dbg_state(dbg_state)
    );

    // Priority starts just after the last winner.
    function automatic int pick(input int last, input logic [3:0] req);
        for (int k = 1; k <= 4; k++) begin
            if (!req[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Model update: a grant ends on release, abort or tenure expiry and
    // leaves one cycle without owner; arbitration only happens with no owner.
    always @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            m_owner <= -1;
            m_last  <= 3;
            m_sel   <= 2'd0;
            m_ten   <= 0;
        end else if (m_owner >= 0) begin
            if (REQ_L[m_owner] || EN_L || (TENURE && m_ten == HOLD - 1))
                m_owner <= -1;
            else
                m_ten <= m_ten + 1;
        end else if (!EN_L && REQ_L != 4'hf) begin
            m_owner <= pick(m_last, REQ_L);
            m_last  <= pick(m_last, REQ_L);
            m_sel   <= 2'(pick(m_last, REQ_L));
            m_ten   <= 0;
        end
    end

    // Scoreboard compare every cycle, away from the active edge.
    always @(negedge CLK) begin
        if (cmp_on) begin
            chk("m_gnt", GNT_L, (m_owner >= 0) ? ~(4'b0001 << m_owner) : 4'hf);
            chk("m_sel", {2'b00, SEL}, {2'b00, m_sel});
            chk("m_g", {3'b000, G_L}, {3'b000, (m_owner < 0)});
            chk("m_busy", {3'b000, BUSY}, {3'b000, (m_owner >= 0)});
            chk("m_excl", {3'b000, ($countones(~GNT_L) <= 1) && (G_L == &GNT_L)}, 4'd1);
        end
    end

    // driver
    initial begin
        RESET_L = 1'b0;
        EN_L    = 1'b0;
        REQ_L   = 4'hf;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_gnt", GNT_L, 4'b1111);
        chk("rst_sel", {2'b00, SEL}, 4'd0);
        chk("rst_g", {3'b000, G_L}, 4'd1);
        chk("rst_busy", {3'b000, BUSY}, 4'd0);
        RESET_L = 1'b1;
        cmp_on  = 1'b1;
        cyc(1);

        // requesters 1 and 3
        REQ_L = 4'b0101;
        cyc(1);
        chk("rq13_g1", GNT_L, 4'b1101);
        chk("rq13_s1", {2'b00, SEL}, 4'd1);
        cyc(2);
        REQ_L = 4'b0111;
        cyc(1);
        chk("rq13_gap", GNT_L, 4'b1111);
        chk("rq13_gaps", {2'b00, SEL}, 4'd1);
        REQ_L = 4'b0101;
        cyc(1);
        chk("rq13_g3", GNT_L, 4'b0111);
        chk("rq13_s3", {2'b00, SEL}, 4'd3);
        REQ_L = 4'hf;
        cyc(2);

        // all four requesting, two-cycle tenures
        REQ_L = 4'b0000;
        cyc(1);
        for (int i = 0; i < 5; i++) begin
            chk("rot_sel", {2'b00, SEL}, 4'(i % 4));
            chk("rot_gnt", GNT_L, ~(4'b0001 << (i % 4)));
            cyc(1);
            REQ_L = 4'b0001 << (i % 4);
            cyc(1);
            chk("rot_gap", GNT_L, 4'b1111);
            REQ_L = 4'b0000;
            cyc(1);
        end
        REQ_L = 4'hf;
        cyc(2);

        // abort during grant to 2, then wrap to 0
        REQ_L = 4'b1011;
        cyc(1);
        chk("ab_g2", GNT_L, 4'b1011);
        EN_L  = 1'b1;
        REQ_L = 4'b1000;
        cyc(1);
        chk("ab_gap", GNT_L, 4'b1111);
        EN_L = 1'b0;
        cyc(1);
        chk("ab_g0", GNT_L, 4'b1110);
        chk("ab_s0", {2'b00, SEL}, 4'd0);

        // asynchronous reset mid-grant
        @(negedge CLK);
        #2;
        RESET_L = 1'b0;
        #1;
        chk("arst_gnt", GNT_L, 4'b1111);
        chk("arst_sel", {2'b00, SEL}, 4'd0);
        chk("arst_g", {3'b000, G_L}, 4'd1);
        chk("arst_busy", {3'b000, BUSY}, 4'd0);
        REQ_L = 4'hf;
        cyc(1);
        RESET_L = 1'b1;
        cyc(1);

        // requester 0 holding alone
        REQ_L = 4'b1110;
        cyc(1);
`ifdef ARB4_TENURE_EN
        for (int i = 0; i < HOLD; i++) begin
            chk("ten_hold", GNT_L, 4'b1110);
            cyc(1);
        end
        chk("ten_gap", GNT_L, 4'b1111);
        cyc(1);
        chk("ten_regrant", GNT_L, 4'b1110);
`else
        for (int i = 0; i < 40; i++) begin
            chk("hold40", GNT_L, 4'b1110);
            cyc(1);
        end
`endif
        REQ_L = 4'hf;
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
